// File: rtl/grf_wb_arbiter.sv
// Write-port arbiter for the 32x32 GRF: pipeline W stage vs. a buffered secondary requester.
// Optional stall-cycle counter port enabled by defining GRF_ARB_PERF_EN.
module grf_wb_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       p_we,
  input  logic [4:0]                 p_addr,
  input  logic [31:0]                p_data,
  output logic                       p_stall,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [4:0]                 s_addr,
  input  logic [31:0]                s_data,
  input  logic [4:0]                 q_addr1,
  input  logic [4:0]                 q_addr2,
  output logic                       q_busy1,
  output logic                       q_busy2,
  output logic                       grf_we,
  output logic [4:0]                 grf_a3,
  output logic [31:0]                grf_wd,
  output logic [$clog2(DEPTH):0]     fifo_cnt
`ifdef GRF_ARB_PERF_EN
  ,
  output logic [31:0]                perf_stall_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0] ent_valid;
  logic [4:0]       ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt;

  logic p_req, full, empty, head_live, head_dead;
  logic pop, push, p_grant, head_wr;

  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);
  assign head_live = !empty && ent_valid[rd_ptr];
  assign head_dead = !empty && !ent_valid[rd_ptr];
  // Gated by rst so the write port and stall stay quiet while reset is held.
  assign p_req     = rst && p_we && (p_addr != '0);
  assign s_ready   = (cnt < CW'(DEPTH));
  assign push      = rst && s_valid && s_ready && (s_addr != '0);
  assign fifo_cnt  = cnt;

  always_comb begin
    pop     = 1'b0;
    p_grant = 1'b0;
    head_wr = 1'b0;
    p_stall = 1'b0;
    if (rst) begin
      if (head_dead) begin
        pop     = 1'b1;
        p_grant = p_req;
      end else if (p_req && full) begin
        p_stall = 1'b1;
        head_wr = 1'b1;
        pop     = 1'b1;
      end else if (p_req) begin
        p_grant = 1'b1;
      end else if (head_live) begin
        head_wr = 1'b1;
        pop     = 1'b1;
      end
    end
  end

  always_comb begin
    grf_we = 1'b0;
    grf_a3 = '0;
    grf_wd = '0;
    if (p_grant) begin
      grf_we = 1'b1;
      grf_a3 = p_addr;
      grf_wd = p_data;
    end else if (head_wr) begin
      grf_we = 1'b1;
      grf_a3 = ent_addr[rd_ptr];
      grf_wd = ent_data[rd_ptr];
    end
  end

  always_comb begin
    q_busy1 = 1'b0;
    q_busy2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (q_addr1 != '0) && (ent_addr[i] == q_addr1)) q_busy1 = 1'b1;
      if (ent_valid[i] && (q_addr2 != '0) && (ent_addr[i] == q_addr2)) q_busy2 = 1'b1;
    end
  end

  // Later assignments win: squash first, then pop clear, then the push slot
  // (always an unoccupied slot) is marked valid, so a same-cycle push survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (p_grant && ent_valid[i] && (ent_addr[i] == p_addr)) ent_valid[i] <= 1'b0;
      end
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + AW'(1);
      end
      if (push) begin
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= s_addr;
      ent_data[wr_ptr] <= s_data;
    end
  end

`ifdef GRF_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
    end else if (p_stall && (perf_stall_cnt != '1)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/grf_wb_arbiter.md
# grf_wb_arbiter

Write-port arbiter for the 32×32 general register file. It shares the GRF's single write port between the in-order pipeline W stage and a secondary long-latency requester, such as the multiply/divide or a late load return. Secondary writes are buffered in a small FIFO. The block stalls the pipeline only when that FIFO is full, squashes buffered writes made stale by younger pipeline writes, and reports per-register pending status to the decode hazard logic.

## Interface
- DEPTH, 4, secondary write FIFO entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- p_we  in  1  pipeline W-stage write request
- p_addr  in  5  pipeline destination register
- p_data  in  32  pipeline write data
- p_stall  out  1  pipeline write not taken this cycle; W stage holds its request
- s_valid  in  1  secondary write offered
- s_ready  out  1  secondary write accepted when s_valid&&s_ready at the edge
- s_addr  in  5  secondary destination register
- s_data  in  32  secondary write data
- q_addr1, q_addr2  in  5  decode-stage source registers to check
- q_busy1, q_busy2  out  1  queried register has a valid pending FIFO write
- grf_we  out  1  GRF write enable
- grf_a3  out  5  GRF write address
- grf_wd  out  32  GRF write data
- fifo_cnt  out  $clog2(DEPTH)+1  FIFO occupancy, counting valid and squashed entries
- perf_stall_cnt  out  32  stall-cycle counter; present only with the configuration macro

## Operation
- p_req = p_we && p_addr!=0. A write to r0 is never a request: no write, no stall.
- FIFO entry = {valid, addr, data}. Enqueue on s_valid && s_ready && s_addr!=0. A secondary write to r0 is accepted and discarded.
- s_ready = (fifo_cnt < DEPTH). It depends on registered state only; there is no same-cycle pop pass-through.
- Port grant, evaluated combinationally each cycle in priority order:
  1. Head invalid (squashed): pop it with no write port use. The write port then goes to P if p_req.
  2. p_req && full && head valid: p_stall=1; the head is written and popped.
  3. p_req: P is written; p_stall=0.
  4. FIFO non-empty and head valid: the head is written and popped.
  5. Otherwise grf_we=0.
- grf_a3 and grf_wd come from the granted source. When grf_we=0 they are don't-care, but are driven 0.
- Squash: when P is granted with address A, every valid FIFO entry with addr==A has its valid bit cleared at that edge.
  - An entry enqueued in the same cycle is NOT squashed; it is treated as younger.
  - The head popped in the same cycle is unaffected.
- q_busyN = q_addrN!=0 && any valid FIFO entry has addr==q_addrN. The incoming s_* entry is excluded.
- Same-register ordering: FIFO entries are written in FIFO order. The GRF supplies write-to-read bypass itself, so none is needed here.

## Timing
- Pipeline write latency 0: the GRF captures it at the same edge.
- Secondary write latency ≥1 cycle: it is enqueued at edge N and written at edge N+1 at the earliest (empty FIFO, no p_req).
- p_stall is combinational. Stall duration is 1 cycle per full-FIFO conflict.
- Simultaneous push and pop: occupancy is unchanged and the pointers wrap modulo DEPTH.
- Reset (asynchronous, mid-operation included):
  - pointers 0, fifo_cnt 0, all valid bits 0; pending writes are dropped
  - grf_we 0, p_stall 0, s_ready 1, q_busy* 0, perf_stall_cnt 0

## Configuration
- GRF_ARB_PERF_EN defined:
  - perf_stall_cnt increments on every cycle with p_stall=1.
  - The count saturates at 32'hFFFF_FFFF.
  - It clears only on reset.
- Undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Empty FIFO; s writes r5=0x11, next cycle no p_req → grf_we=1, a3=5, wd=0x11 one cycle after accept; fifo_cnt 1→0.
- p writes r3=0xAA every cycle while s pushes 4 entries (DEPTH=4) → FIFO fills and s_ready=0. The next p_req cycle gives p_stall=1 and writes the head; on the following cycle p is written.
- FIFO holds r7; p writes r7=0x22 → q_busy for r7 drops next cycle. The squashed entry is later popped with grf_we driven by p or 0, and r7 is never overwritten with the stale value.
- p_addr=0 with p_we=1 and s_addr=0 offer → no write, no stall; s accepted, fifo_cnt unchanged.
- rst asserted low mid-burst with 3 entries pending → immediately fifo_cnt=0, grf_we=0, s_ready=1. No write to the GRF after release until a new request.
- With GRF_ARB_PERF_EN, 3 stall cycles → perf_stall_cnt=3. Without it, the module elaborates with no perf port.
